cycseq: RTL and testbench

Memory cycle sequencer for Tom's external bus. It accepts one transfer request from the bus arbiter, splits it into one or more memory sub-cycles according to the latched memory width, and steps the byte address `ba[2:0]`. It also generates the `ack`, `ourack`, `idle` and `reads` qualifiers consumed by the downstream data-path steering logic (`den`, `dmuxu`, `dmuxd`, `dren`). The memory controller handshakes each sub-cycle through `mreq`/`memack`.

---
 rtl/cycseq.sv | 129 ++++++++++++
 tb/tb_cycseq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cycseq.sv
// cycseq: memory cycle sequencer. Accepts one bus transfer, splits it into
// memory-width sub-cycles, steps the byte address and handshakes each
// sub-cycle with the memory controller through mreq/memack.
module cycseq (
  input  logic       clk,
  input  logic       resetl,
  input  logic       req,
  input  logic       rw,
  input  logic [1:0] siz,
  input  logic [2:0] a,
  input  logic       mws8,
  input  logic       mws16,
  input  logic       mws64,
  input  logic       memack,
  output logic       ack,
  output logic       mreq,
  output logic       ourack,
  output logic       ba_0,
  output logic       ba_1,
  output logic       ba_2,
  output logic       reads,
  output logic       idle,
  output logic       last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CYC  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       ack_q,   ack_d;
  logic       rw_q,    rw_d;
  logic [1:0] mbl_q,   mbl_d;   // log2 of memory width in bytes
  logic [2:0] cnt_q,   cnt_d;   // remaining sub-cycles minus one
  logic [2:0] ba_q,    ba_d;

  logic [1:0] mbl_in;
  logic [2:0] low_mask;
  logic [2:0] sba;
  logic [3:0] span;
  logic [2:0] nm1;
  logic [2:0] step;

  // Decode request-time width, aligned start address and sub-cycle count.
  always_comb begin
    if (mws8)       mbl_in = 2'd0;
    else if (mws16) mbl_in = 2'd1;
    else if (mws64) mbl_in = 2'd3;
    else            mbl_in = 2'd2;

    // For siz=3 the shift wraps to 0 and the subtraction yields all ones,
    // which aligns a 64-bit transfer to byte 0.
    low_mask = (3'd1 << siz) - 3'd1;
    sba      = a & ~low_mask;

    span = 4'd1;
    if (siz > mbl_in) span = 4'd1 << (siz - mbl_in);
    nm1  = 3'(span - 4'd1);

    step = 3'd1 << mbl_q;
  end

  // Next-state and datapath update for the IDLE/CYC/DATA sequencer.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rw_d    = rw_q;
    mbl_d   = mbl_q;
    cnt_d   = cnt_q;
    ba_d    = ba_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = rw;
          mbl_d   = mbl_in;
          cnt_d   = nm1;
          ba_d    = sba;
          ack_d   = 1'b1;
          state_d = S_CYC;
        end
      end
      S_CYC: begin
        if (memack) state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q != 3'd0) begin
          cnt_d   = cnt_q - 3'd1;
          ba_d    = ba_q + step;
          state_d = S_CYC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetl) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rw_q    <= 1'b0;
      mbl_q   <= '0;
      cnt_q   <= '0;
      ba_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rw_q    <= rw_d;
      mbl_q   <= mbl_d;
      cnt_q   <= cnt_d;
      ba_q    <= ba_d;
    end
  end

  assign ack    = ack_q;
  assign mreq   = (state_q == S_CYC);
  assign ourack = (state_q == S_DATA);
  assign idle   = (state_q == S_IDLE);
  assign last   = (cnt_q == 3'd0) && (state_q != S_IDLE);
  assign reads  = rw_q;
  assign ba_0   = ba_q[0];
  assign ba_1   = ba_q[1];
  assign ba_2   = ba_q[2];

endmodule

// File: tb/tb_cycseq.sv
// Directed bench for cycseq. Inputs change and outputs are sampled 1ns after
// each rising edge; expected output vectors are written out by hand.
module tb_cycseq;

  logic       clk;
  logic       resetl;
  logic       req;
  logic       rw;
  logic [1:0] siz;
  logic [2:0] a;
  logic       mws8, mws16, mws64;
  logic       memack;
  logic       ack, mreq, ourack, ba_0, ba_1, ba_2, reads, idle, last;

  int unsigned checks;
  int unsigned failures;

  cycseq dut (
    .clk    (clk),
    .resetl (resetl),
    .req    (req),
    .rw     (rw),
    .siz    (siz),
    .a      (a),
    .mws8   (mws8),
    .mws16  (mws16),
    .mws64  (mws64),
    .memack (memack),
    .ack    (ack),
    .mreq   (mreq),
    .ourack (ourack),
    .ba_0   (ba_0),
    .ba_1   (ba_1),
    .ba_2   (ba_2),
    .reads  (reads),
    .idle   (idle),
    .last   (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Vector order: ack mreq ourack ba[2:0] reads idle last
  task automatic expect_outs(input string tag, input logic e_ack, input logic e_mreq,
                             input logic e_our, input logic [2:0] e_ba, input logic e_reads,
                             input logic e_idle, input logic e_last);
    check(tag, {7'd0, ack, mreq, ourack, ba_2, ba_1, ba_0, reads, idle, last},
               {7'd0, e_ack, e_mreq, e_our, e_ba, e_reads, e_idle, e_last});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic r, input logic [1:0] s, input logic [2:0] ad,
                       input logic w8, input logic w16, input logic w64);
    rw = r; siz = s; a = ad; mws8 = w8; mws16 = w16; mws64 = w64;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetl = 1'b0; req = 1'b0; memack = 1'b0;
    setup(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    expect_outs("reset", 0, 0, 0, 3'd0, 0, 1, 0);
    resetl = 1'b1;
    step();
    expect_outs("idle_after_reset", 0, 0, 0, 3'd0, 0, 1, 0);

    // 64-bit read over 8-bit memory, a=3 aligns to 0, 8 sub-cycles.
    setup(1'b1, 2'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    memack = 1'b1; req = 1'b1;
    step();
    req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_outs($sformatf("t1_cyc%0d", k), k == 0, 1, 0, 3'(k), 1, 0, k == 7);
      step();
      expect_outs($sformatf("t1_data%0d", k), 0, 0, 1, 3'(k), 1, 0, k == 7);
      step();
    end
    expect_outs("t1_idle", 0, 0, 0, 3'd7, 1, 1, 0);

    // 16-bit write over 32-bit memory, a=7 aligns to 6, single sub-cycle.
    setup(1'b0, 2'd1, 3'd7, 1'b0, 1'b0, 1'b0);
    req = 1'b1;
    step();
    req = 1'b0;
    expect_outs("t2_cyc", 1, 1, 0, 3'd6, 0, 0, 1);
    step();
    expect_outs("t2_data", 0, 0, 1, 3'd6, 0, 0, 1);
    step();
    expect_outs("t2_idle", 0, 0, 0, 3'd6, 0, 1, 0);

    // 32-bit read over 16-bit memory, a=5 -> ba 4 then 6, memack after 3 waits.
    setup(1'b1, 2'd2, 3'd5, 1'b0, 1'b1, 1'b0);
    memack = 1'b0; req = 1'b1;
    step();
    req = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 4; w++) begin
        expect_outs($sformatf("t3_cyc%0d_w%0d", s, w), (s == 0) && (w == 0), 1, 0,
                    (s == 0) ? 3'd4 : 3'd6, 1, 0, s == 1);
        memack = (w == 3);
        step();
      end
      memack = 1'b0;
      expect_outs($sformatf("t3_data%0d", s), 0, 0, 1, (s == 0) ? 3'd4 : 3'd6, 1, 0, s == 1);
      step();
    end
    expect_outs("t3_idle", 0, 0, 0, 3'd6, 1, 1, 0);

    // memack and req held high: single-cycle transfers every 3 cycles.
    setup(1'b0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0);
    memack = 1'b1; req = 1'b1;
    step();
    for (int p = 0; p < 3; p++) begin
      expect_outs($sformatf("t4_cyc%0d", p), 1, 1, 0, 3'd2, 0, 0, 1);
      step();
      expect_outs($sformatf("t4_data%0d", p), 0, 0, 1, 3'd2, 0, 0, 1);
      step();
      expect_outs($sformatf("t4_idle%0d", p), 0, 0, 0, 3'd2, 0, 1, 0);
      if (p == 2) req = 1'b0;
      step();
    end
    expect_outs("t4_stay_idle", 0, 0, 0, 3'd2, 0, 1, 0);

    // Reset during CYC of the 3rd sub-cycle of a 64-bit / 8-bit transfer.
    setup(1'b1, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    step();
    step();
    expect_outs("t5_cyc2", 0, 1, 0, 3'd2, 1, 0, 0);
    resetl = 1'b0;
    step();
    resetl = 1'b1;
    expect_outs("t5_reset", 0, 0, 0, 3'd0, 0, 1, 0);
    step();
    expect_outs("t5_no_ourack", 0, 0, 0, 3'd0, 0, 1, 0);
    // Fresh 16-bit read over 8-bit memory, a=5 -> ba 4, 5.
    setup(1'b1, 2'd1, 3'd5, 1'b1, 1'b0, 1'b0);
    req = 1'b1;
    step();
    req = 1'b0;
    expect_outs("t5_new_cyc0", 1, 1, 0, 3'd4, 1, 0, 0);
    step();
    expect_outs("t5_new_data0", 0, 0, 1, 3'd4, 1, 0, 0);
    step();
    expect_outs("t5_new_cyc1", 0, 1, 0, 3'd5, 1, 0, 1);
    step();
    expect_outs("t5_new_data1", 0, 0, 1, 3'd5, 1, 0, 1);
    step();
    expect_outs("t5_new_idle", 0, 0, 0, 3'd5, 1, 1, 0);

    // 8-bit read with mws8 and mws64 both set: 8-bit width wins, ba = a.
    setup(1'b1, 2'd0, 3'd5, 1'b1, 1'b0, 1'b1);
    req = 1'b1;
    step();
    req = 1'b0;
    expect_outs("t6_cyc", 1, 1, 0, 3'd5, 1, 0, 1);
    step();
    expect_outs("t6_data", 0, 0, 1, 3'd5, 1, 0, 1);
    step();
    expect_outs("t6_idle", 0, 0, 0, 3'd5, 1, 1, 0);

    // 32-bit read with mws64 only: one sub-cycle, aligned to 4.
    setup(1'b1, 2'd2, 3'd6, 1'b0, 1'b0, 1'b1);
    req = 1'b1;
    step();
    req = 1'b0;
    expect_outs("t7_cyc", 1, 1, 0, 3'd4, 1, 0, 1);
    step();
    expect_outs("t7_data", 0, 0, 1, 3'd4, 1, 0, 1);
    step();
    expect_outs("t7_idle", 0, 0, 0, 3'd4, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
